// File: rtl/dsi_pkg.sv
// Shared types and constants for the DSI lane scheduler.
package dsi_pkg;

  localparam int unsigned MAX_LANES  = 4;
  localparam logic [7:0]  DUMMY_BYTE = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  // Enabled lane count: 0 means one lane, anything above the port count saturates.
  function automatic int unsigned clamp_lanes(int unsigned n, int unsigned lanes);
    if (n == 0) return 1;
    if (n > lanes) return lanes;
    return n;
  endfunction

endpackage

// File: rtl/dsi_stripe_buf.sv
// One stripe of lane slots: bytes land at the write index, and the tail of a
// short final stripe is padded with dummy bytes in the same cycle.
module dsi_stripe_buf
  import dsi_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned LN_W  = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               acc_i,
  input  logic               last_i,
  input  logic [7:0]         data_i,
  input  logic [LN_W-1:0]    n_i,
  output logic [8*LANES-1:0] slot_data_o,
  output logic [LANES-1:0]   slot_dummy_o,
  output logic [LN_W-1:0]    fill_cnt_o
);

  logic [LANES-1:0][7:0] slot_data_q, slot_data_d;
  logic [LANES-1:0]      slot_dummy_q, slot_dummy_d;
  logic [LN_W-1:0]       fill_cnt_q, fill_cnt_d;

  always_comb begin
    slot_data_d  = slot_data_q;
    slot_dummy_d = slot_dummy_q;
    fill_cnt_d   = fill_cnt_q;
    if (clr_i) begin
      slot_data_d  = '0;
      slot_dummy_d = '0;
      fill_cnt_d   = '0;
    end else if (acc_i) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (LN_W'(i) == fill_cnt_q) begin
          slot_data_d[i]  = data_i;
          slot_dummy_d[i] = 1'b0;
        end else if (last_i && (LN_W'(i) > fill_cnt_q) && (LN_W'(i) < n_i)) begin
          // Pad the unfilled enabled slots behind the final byte.
          slot_data_d[i]  = DUMMY_BYTE;
          slot_dummy_d[i] = 1'b1;
        end
      end
      fill_cnt_d = fill_cnt_q + LN_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      slot_data_q  <= '0;
      slot_dummy_q <= '0;
      fill_cnt_q   <= '0;
    end else begin
      slot_data_q  <= slot_data_d;
      slot_dummy_q <= slot_dummy_d;
      fill_cnt_q   <= fill_cnt_d;
    end
  end

  assign slot_data_o  = slot_data_q;
  assign slot_dummy_o = slot_dummy_q;
  assign fill_cnt_o   = fill_cnt_q;

endmodule

// File: rtl/dsi_lanes_scheduler.sv
// Stripes an upstream packet byte stream round-robin over N lanes and holds
// off the next packet until every enabled lane is back in LP-STOP.
module dsi_lanes_scheduler
  import dsi_pkg::*;
#(
  parameter int unsigned LANES        = 4,
  parameter int unsigned LN_W         = 3,
  parameter int unsigned WAIT_TIMEOUT = 64
) (
  input  logic               clk_base,
  input  logic               reset_n,
  input  logic [LN_W-1:0]    lanes_number,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [7:0]         s_data,
  input  logic               s_last,
  input  logic               s_hs,
  output logic [8*LANES-1:0] lane_data,
  output logic [LANES-1:0]   lane_write,
  output logic [LANES-1:0]   lane_eof,
  output logic [LANES-1:0]   lane_dummy,
  output logic [LANES-1:0]   lane_type,
  input  logic [LANES-1:0]   lane_ready,
  input  logic [LANES-1:0]   lane_active,
  output logic               busy,
  output logic               err_timeout
);

  localparam int unsigned LANES_C = (LANES < MAX_LANES) ? LANES : MAX_LANES;
  localparam int unsigned CNT_W   = $clog2(WAIT_TIMEOUT + 1);

  state_e             state_q;
  logic [LN_W-1:0]    n_q;
  logic               pkt_hs_q;
  logic               first_q;
  logic               eof_q;
  logic               seen_q;
  logic [CNT_W-1:0]   wcnt_q;
  logic               err_q;
  logic [8*LANES-1:0] lane_data_q;
  logic [LANES-1:0]   lane_write_q, lane_eof_q, lane_dummy_q, lane_type_q;

  logic [LN_W-1:0]    n_in;
  logic [LANES-1:0]   run_mask, idle_mask;
  logic [8*LANES-1:0] data_mask;
  logic [8*LANES-1:0] slot_data;
  logic [LANES-1:0]   slot_dummy;
  logic [LN_W-1:0]    fill_cnt;
  logic               accept, close_stripe, ready_all, act_any, idle_clear, buf_clr;

  assign n_in = LN_W'(clamp_lanes(32'(lanes_number), LANES_C));

  // Lane enables for the running packet and for the count offered in IDLE.
  always_comb begin
    run_mask  = '0;
    idle_mask = '0;
    data_mask = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      run_mask[i]       = (LN_W'(i) < n_q);
      idle_mask[i]      = (LN_W'(i) < n_in);
      data_mask[8*i+:8] = {8{run_mask[i]}};
    end
  end

  assign accept       = s_valid && (state_q == ST_FILL);
  assign close_stripe = accept && (s_last || (fill_cnt == (n_q - LN_W'(1))));
  assign ready_all    = &(lane_ready | ~run_mask);
  assign act_any      = |(lane_active & run_mask);
  assign idle_clear   = ~|(lane_active & idle_mask);
  assign buf_clr      = (state_q == ST_WRITE) && ready_all;

  dsi_stripe_buf #(
    .LANES (LANES),
    .LN_W  (LN_W)
  ) u_buf (
    .clk_i        (clk_base),
    .rst_ni       (reset_n),
    .clr_i        (buf_clr),
    .acc_i        (accept),
    .last_i       (s_last),
    .data_i       (s_data),
    .n_i          (n_q),
    .slot_data_o  (slot_data),
    .slot_dummy_o (slot_dummy),
    .fill_cnt_o   (fill_cnt)
  );

  always_ff @(posedge clk_base) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      pkt_hs_q     <= 1'b0;
      first_q      <= 1'b0;
      eof_q        <= 1'b0;
      seen_q       <= 1'b0;
      wcnt_q       <= '0;
      err_q        <= 1'b0;
      lane_data_q  <= '0;
      lane_write_q <= '0;
      lane_eof_q   <= '0;
      lane_dummy_q <= '0;
      lane_type_q  <= '0;
    end else begin
      // Lane strobes and their qualifiers only live for the write cycle.
      lane_data_q  <= '0;
      lane_write_q <= '0;
      lane_eof_q   <= '0;
      lane_dummy_q <= '0;
      lane_type_q  <= '0;
      err_q        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (idle_clear) begin
            n_q     <= n_in;
            first_q <= 1'b1;
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (accept) begin
            if (first_q) begin
              pkt_hs_q <= s_hs;
              first_q  <= 1'b0;
            end
            if (close_stripe) begin
              eof_q   <= s_last;
              state_q <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (ready_all) begin
            lane_write_q <= run_mask;
            lane_data_q  <= slot_data & data_mask;
            lane_dummy_q <= slot_dummy & run_mask;
            lane_eof_q   <= {LANES{eof_q}} & run_mask;
            lane_type_q  <= {LANES{pkt_hs_q}} & run_mask;
            wcnt_q       <= '0;
            seen_q       <= 1'b0;
            eof_q        <= 1'b0;
            state_q      <= eof_q ? ST_WAIT : ST_FILL;
          end
        end
        ST_WAIT: begin
          if (wcnt_q != CNT_W'(WAIT_TIMEOUT)) wcnt_q <= wcnt_q + CNT_W'(1);
          // Lanes must be seen going active before their return to STOP counts.
          if (seen_q) begin
            if (!act_any) state_q <= ST_IDLE;
          end else if (act_any) begin
            seen_q <= 1'b1;
          end else if (wcnt_q == CNT_W'(WAIT_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready     = (state_q == ST_FILL);
  assign busy        = (state_q != ST_IDLE);
  assign err_timeout = err_q;
  assign lane_data   = lane_data_q;
  assign lane_write  = lane_write_q;
  assign lane_eof    = lane_eof_q;
  assign lane_dummy  = lane_dummy_q;
  assign lane_type   = lane_type_q;

endmodule

// File: tb/tb_dsi_lanes_scheduler.sv
// Bench for dsi_lanes_scheduler: directed vector table, multi-cycle corner
// sequences and randomized packets against a striping reference model.
module tb_dsi_lanes_scheduler;

  localparam int unsigned LANES = 4;
  localparam int unsigned LN_W  = 3;

  logic              clk_base = 1'b0;
  logic              reset_n;
  logic [LN_W-1:0]   lanes_number;
  logic              s_valid, s_ready, s_last, s_hs;
  logic [7:0]        s_data;
  logic [8*LANES-1:0] lane_data;
  logic [LANES-1:0]  lane_write, lane_eof, lane_dummy, lane_type, lane_ready, lane_active;
  logic              busy, err_timeout;

  always #5 clk_base = ~clk_base;

  dsi_lanes_scheduler #(.LANES(LANES), .LN_W(LN_W), .WAIT_TIMEOUT(64)) dut (
    .clk_base(clk_base), .reset_n(reset_n), .lanes_number(lanes_number),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_hs(s_hs),
    .lane_data(lane_data), .lane_write(lane_write), .lane_eof(lane_eof),
    .lane_dummy(lane_dummy), .lane_type(lane_type), .lane_ready(lane_ready),
    .lane_active(lane_active), .busy(busy), .err_timeout(err_timeout)
  );

  typedef struct {
    logic [3:0]  w, e, d, t;
    logic [31:0] data;
    logic        rdy_ok;
  } wr_t;

  typedef struct {
    logic [2:0]  ln;
    int unsigned len;
    logic [7:0]  base;
    logic        hs;
    int unsigned exp_wr;
    logic [3:0]  exp_dmy;
  } vec_t;

  wr_t         wq[$];
  int          rd_idx = 0;
  int          eof_cnt = 0;
  int          err_cnt = 0;
  logic [3:0]  prev_ready = '0;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  pkt[$];
  logic        rand_ready = 1'b0;
  logic [2:0]  next_ln;
  logic [3:0]  last_dummy;
  int unsigned last_nwr;
  vec_t        tbl[8];

  // Write monitor; prev_ready is what the DUT sampled before the write edge.
  always @(negedge clk_base) begin
    wr_t r;
    if (lane_write != '0) begin
      r.w = lane_write; r.e = lane_eof; r.d = lane_dummy; r.t = lane_type;
      r.data = lane_data;
      r.rdy_ok = ((prev_ready & lane_write) == lane_write);
      wq.push_back(r);
      if (lane_eof != '0) eof_cnt++;
    end
    if (err_timeout) err_cnt++;
    prev_ready = lane_ready;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int unsigned clampn(input int unsigned v);
    if (v == 0) return 1;
    return (v > 4) ? 4 : v;
  endfunction

  function automatic logic [3:0] mask_of(input int unsigned n);
    return 4'((1 << n) - 1);
  endfunction

  task automatic tick();
    @(posedge clk_base); #1;
    if (rand_ready) lane_ready = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
  endtask

  task automatic send_bytes(input logic hs, input bit gaps, input bit ln_change);
    for (int i = 0; i < pkt.size(); i++) begin
      bit acc;
      int guard;
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      s_valid = 1'b1;
      s_data  = pkt[i];
      s_last  = (i == pkt.size() - 1);
      s_hs    = (i == 0) ? hs : 1'($urandom);
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 300) begin
        acc = s_ready;
        tick();
        guard++;
      end
      if (!acc) begin
        check("accept_timeout", 0, 1);
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
      if (i == 0 && ln_change) lanes_number = 3'd4;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_eof(input int base);
    int guard = 0;
    while (eof_cnt <= base && guard < 400) begin
      tick();
      guard++;
    end
    if (eof_cnt <= base) check("eof_write_timeout", 0, 1);
  endtask

  // Lanes go active after the EOF stripe, then return to STOP; the next count is offered meanwhile.
  task automatic finish_pkt(input int unsigned n);
    logic [3:0] mask, nmask, junk;
    int guard;
    mask  = mask_of(n);
    nmask = mask_of(clampn(next_ln));
    junk  = 4'($urandom) & ~mask & ~nmask;
    repeat ($urandom_range(0, 3)) tick();
    lane_active = mask | junk;
    repeat ($urandom_range(1, 4)) tick();
    lanes_number = next_ln;
    lane_active  = junk;
    guard = 0;
    while (!s_ready && guard < 30) begin
      tick();
      guard++;
    end
    check("back_to_fill", s_ready, 1);
    lane_active = '0;
  endtask

  // Reference: byte k of the packet goes to stripe k/N, lane k%N; short tail padded.
  task automatic compare_pkt(input int unsigned n, input logic hs, input string tag);
    int unsigned len, nst;
    logic [3:0] mask, w, e, d, t;
    logic [31:0] data;
    wr_t got;
    len  = pkt.size();
    nst  = (len + n - 1) / n;
    mask = mask_of(n);
    last_nwr = wq.size() - rd_idx;
    check({tag, "_nwrites"}, 64'(last_nwr), 64'(nst));
    last_dummy = 'x;
    for (int unsigned s = 0; s < nst; s++) begin
      if (rd_idx >= wq.size()) break;
      w = mask;
      e = (s == nst - 1) ? mask : 4'h0;
      t = hs ? mask : 4'h0;
      d = '0;
      data = '0;
      for (int unsigned i = 0; i < n; i++) begin
        if (s * n + i < len) data[8*i+:8] = pkt[s*n+i];
        else d[i] = 1'b1;
      end
      got = wq[rd_idx];
      rd_idx++;
      check({tag, "_stripe"}, {got.w, got.e, got.d, got.t, got.data}, {w, e, d, t, data});
      check({tag, "_ready_before_write"}, got.rdy_ok, 1);
      if (s == nst - 1) last_dummy = got.d;
    end
    rd_idx = wq.size();
  endtask

  task automatic run_pkt(input int unsigned n, input logic hs, input bit gaps,
                         input bit ln_change, input string tag);
    int eb, erb;
    eb  = eof_cnt;
    erb = err_cnt;
    send_bytes(hs, gaps, ln_change);
    wait_eof(eb);
    finish_pkt(n);
    compare_pkt(n, hs, tag);
    check({tag, "_no_timeout"}, 64'(err_cnt), 64'(erb));
  endtask

  initial begin
    int bad, cnt, guard;
    int unsigned cur;
    tbl[0] = '{3'd4, 8, 8'h01, 1'b1, 2, 4'b0000};
    tbl[1] = '{3'd4, 5, 8'hAA, 1'b0, 2, 4'b1110};
    tbl[2] = '{3'd2, 3, 8'h10, 1'b1, 2, 4'b0010};
    tbl[3] = '{3'd1, 3, 8'h20, 1'b0, 3, 4'b0000};
    tbl[4] = '{3'd0, 2, 8'h30, 1'b1, 2, 4'b0000};
    tbl[5] = '{3'd7, 6, 8'h40, 1'b0, 2, 4'b1100};
    tbl[6] = '{3'd3, 3, 8'h50, 1'b1, 1, 4'b0000};
    tbl[7] = '{3'd3, 1, 8'h60, 1'b0, 1, 4'b0110};

    reset_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_hs = 1'b0; s_data = '0;
    lane_ready = 4'hF; lane_active = '0; lanes_number = tbl[0].ln; next_ln = tbl[0].ln;
    repeat (3) tick();
    check("reset_outputs",
          {s_ready, busy, err_timeout, lane_write, lane_eof, lane_dummy, lane_type, lane_data}, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) begin
      next_ln = (i < 7) ? tbl[i+1].ln : 3'd2;
      pkt.delete();
      for (int unsigned k = 0; k < tbl[i].len; k++) pkt.push_back(tbl[i].base + 8'(k));
      run_pkt(clampn(tbl[i].ln), tbl[i].hs, 1'b0, 1'b0, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_write_count", i), 64'(last_nwr), 64'(tbl[i].exp_wr));
      check($sformatf("tbl%0d_last_dummy", i), last_dummy, tbl[i].exp_dmy);
    end

    // N=2 with lanes_number raised to 4 after the first byte.
    next_ln = 3'd4;
    pkt.delete();
    for (int k = 0; k < 3; k++) pkt.push_back(8'h70 + 8'(k));
    run_pkt(2, 1'b1, 1'b0, 1'b1, "ln_change");

    // lane_ready[1] low for ten WRITE cycles.
    pkt.delete();
    for (int k = 0; k < 4; k++) pkt.push_back(8'hC0 + 8'(k));
    begin
      int eb;
      eb = eof_cnt;
      lane_ready = 4'b1101;
      send_bytes(1'b0, 1'b0, 1'b0);
      bad = 0;
      repeat (10) begin
        @(negedge clk_base);
        if (s_ready || lane_write != '0) bad++;
      end
      check("stall_quiet", 64'(bad), 0);
      @(posedge clk_base); #1;
      lane_ready = 4'hF;
      @(negedge clk_base);
      check("no_early_write", lane_write, 4'h0);
      @(negedge clk_base);
      check("write_after_ready", lane_write, 4'hF);
      wait_eof(eb);
      finish_pkt(4);
      compare_pkt(4, 1'b0, "stall");
    end

    // Lanes never go active after EOF: timeout after 64 WAIT cycles.
    pkt.delete();
    for (int k = 0; k < 3; k++) pkt.push_back(8'h90 + 8'(k));
    send_bytes(1'b1, 1'b0, 1'b0);
    guard = 0;
    do begin
      @(negedge clk_base);
      guard++;
    end while (!(lane_write != '0 && lane_eof != '0) && guard < 50);
    check("timeout_eof_seen", lane_eof, 4'hF);
    cnt = 0;
    do begin
      @(negedge clk_base);
      cnt++;
    end while (!err_timeout && cnt < 200);
    check("timeout_cycles", 64'(cnt), 64);
    check("idle_at_timeout", busy, 0);
    @(negedge clk_base);
    check("err_one_cycle", err_timeout, 0);
    compare_pkt(4, 1'b1, "timeout");

    // Next packet is held until lanes go active and back to STOP.
    pkt.delete();
    pkt.push_back(8'hB1); pkt.push_back(8'hB2);
    begin
      int eb;
      eb = eof_cnt;
      send_bytes(1'b0, 1'b0, 1'b0);
      wait_eof(eb);
    end
    bad = 0;
    repeat (5) begin tick(); if (s_ready) bad++; end
    lane_active = 4'hF;
    repeat (4) begin tick(); if (s_ready) bad++; end
    lane_active = '0;
    check("held_until_active_drop", 64'(bad), 0);
    guard = 0;
    while (!s_ready && guard < 10) begin tick(); guard++; end
    check("released_after_drop", s_ready, 1);
    compare_pkt(4, 1'b0, "active_seq");

    // Reset pulse with a partial stripe buffered.
    s_valid = 1'b1; s_last = 1'b0; s_hs = 1'b1; s_data = 8'hD0;
    tick();
    s_data = 8'hD1;
    tick();
    s_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    check("reset_mid_fill",
          {s_ready, busy, err_timeout, lane_write, lane_eof, lane_dummy, lane_type, lane_data}, 0);
    reset_n = 1'b1;
    tick();
    next_ln = 3'($urandom_range(0, 7));
    pkt.delete();
    for (int k = 0; k < 4; k++) pkt.push_back(8'hE0 + 8'(k));
    run_pkt(4, 1'b1, 1'b0, 1'b0, "post_reset");

    // Randomized packets, lane counts, gaps and ready stalls.
    rand_ready = 1'b1;
    cur = clampn(next_ln);
    for (int r = 0; r < 40; r++) begin
      int unsigned len;
      next_ln = 3'($urandom_range(0, 7));
      len = $urandom_range(1, 13);
      pkt.delete();
      for (int unsigned k = 0; k < len; k++) pkt.push_back(8'($urandom));
      run_pkt(cur, 1'($urandom), 1'b1, 1'b0, "rand");
      cur = clampn(next_ln);
    end
    rand_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
